refill_memory: RTL
==================

REFILL_MEMORY -- requirements
Module: refill_memory

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the word count of the backing store; power of two, at least 16.
REQ-002 SHALL have parameter LATENCY, default 4, meaning the access delay in cycles; legal range 1..15.
REQ-003 SHALL have port clock, input, 1, the system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block idle and able to accept a request.
REQ-007 SHALL have port req_write, input, 1, 1 = single-word write, 0 = 16-word line read.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, write data.
REQ-010 SHALL have port resp_valid, output, 1, read beat present.
REQ-011 SHALL have port resp_data, output, 32, read beat data.
REQ-012 SHALL have port resp_word, output, 4, word offset within the line for the current beat.
REQ-013 SHALL have port resp_last, output, 1, final beat of the line (word 15).
REQ-014 SHALL have port wr_done, output, 1, one-cycle write-completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, BURST and WRITE_DONE.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid && req_ready; in that case req_write, req_addr and req_wdata are latched, the state goes to WAIT and the latency counter is loaded.
REQ-018 req_valid outside IDLE SHALL be ignored with no side effects.
REQ-019 The word index SHALL be req_addr[log2(MEM_WORDS)+1:2]; higher address bits and byte offset bits [1:0] are ignored, so addresses alias modulo MEM_WORDS*4 bytes.
REQ-020 A line read SHALL use line base = word index with bits [3:0] forced to 0.
REQ-021 Timing SHALL be measured from the accept edge A: WAIT lasts exactly LATENCY cycles, with the counter decrementing each edge.
REQ-022 Read: at edge A+LATENCY the state SHALL enter BURST, and beat k (k = 0..15) is presented during the cycle after edge A+LATENCY+k.
REQ-023 Each read beat SHALL drive resp_valid=1, resp_word=k and resp_data=mem[base+k].
REQ-024 Beats SHALL be on 16 consecutive cycles, in order, with no gaps and no backpressure.
REQ-025 resp_last SHALL be 1 only with beat 15.
REQ-026 The edge after beat 15 SHALL return the state to IDLE, making req_ready 1 in the next cycle.
REQ-027 Write: mem[index] SHALL be updated with the latched wdata at edge A+LATENCY.
REQ-028 wr_done SHALL be 1 for exactly the following cycle (state WRITE_DONE), then the state returns to IDLE.
REQ-029 A write SHALL produce no resp_valid.
REQ-030 A read issued after a write completes SHALL return the new data; there is no read-during-write hazard, since only one request is outstanding.
REQ-031 When resp_valid=0, resp_data, resp_word and resp_last SHALL be 0.
REQ-032 All outputs SHALL be registered, with no combinational path from req_* to any output except req_ready, which is decoded from state only.

Reset
REQ-033 Reset assertion SHALL force state IDLE, counters 0, req_ready=1, and resp_valid, resp_data, resp_word, resp_last, wr_done = 0, regardless of clock.
REQ-034 Reset during WAIT or BURST SHALL abort the transaction with no further beats; a write reset before edge A+LATENCY SHALL leave memory unchanged.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 After reset deasserts, the first request SHALL be accepted on the first edge with req_valid=1.

Verification
REQ-037 Reset check: assert reset mid-cycle -> all outputs 0 and req_ready=1 immediately; hold 3 cycles, release -> unchanged.
REQ-038 Write then read, LATENCY=4: write addr 0x0000_0048, data 0xDEAD_BEEF -> wr_done high the cycle after edge A+4 only. Then read addr 0x0000_0040 -> first beat the cycle after edge A+4; beat word 2 = 0xDEAD_BEEF; 16 beats; resp_last only on word 15.
REQ-039 Line fill: preload mem[64..79]=64..79, read addr 0x0000_0107 -> resp_data 64..79 on consecutive cycles with resp_word 0..15; req_ready low throughout and high the cycle after the last beat.
REQ-040 Alias/busy: with MEM_WORDS=1024, write addr 0x0000_1004 -> mem[1] updated. A req_valid pulse during BURST -> ignored, no extra response.
REQ-041 Reset mid-operation: reset at beat 5 -> resp_valid drops immediately, no further beats. A write aborted in WAIT -> target word retains its old value.
REQ-042 LATENCY=1 back-to-back: read accepted the cycle after a previous line's last beat -> first beat the cycle after edge A+1, with no overlap with the previous burst.

Source files
------------

// File: rtl/refill_memory.sv
// Line-refill backing store: 16-word burst reads, single-word writes,
// fixed access latency; one request outstanding at a time.
module refill_memory #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_word,
  output logic        resp_last,
  output logic        wr_done
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT       = 2'd1;
  localparam logic [1:0] BURST      = 2'd2;
  localparam logic [1:0] WRITE_DONE = 2'd3;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    beat_q, beat_d;
  logic          write_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    word_q, word_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic [31:0]   mem_q [MEM_WORDS];

  logic          accept;
  logic          wait_done;
  logic [3:0]    rd_word;
  logic [AW-1:0] rd_idx;
  logic          unused_addr;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign wait_done  = (state_q == WAIT) && (cnt_q == 4'd0);

  // Next beat to present; WAIT prefetches beat 0 of the line.
  assign rd_word = (state_q == BURST) ? beat_q + 4'd1 : 4'd0;
  assign rd_idx  = {idx_q[AW-1:4], rd_word};

  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_word  = word_q;
  assign resp_last  = last_q;
  assign wr_done    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    valid_d = 1'b0;
    data_d  = 32'd0;
    word_d  = 4'd0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = LOAD;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (write_q) begin
          state_d = WRITE_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = BURST;
          beat_d  = 4'd0;
          valid_d = 1'b1;
          data_d  = mem_q[rd_idx];
        end
      end
      BURST: begin
        if (beat_q == 4'd15) begin
          state_d = IDLE;
          beat_d  = 4'd0;
        end else begin
          beat_d  = rd_word;
          valid_d = 1'b1;
          data_d  = mem_q[rd_idx];
          word_d  = rd_word;
          last_d  = (rd_word == 4'd15);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      beat_q  <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      word_q  <= 4'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      word_q  <= word_d;
      last_q  <= last_d;
      done_q  <= done_d;
      if (accept) begin
        write_q <= req_write;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // Contents survive reset; an aborted write never reaches this edge.
  always_ff @(posedge clock) begin
    if (wait_done && write_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
